mmcm_phase_stepper: RTL

- Sequencer for the MMCM dynamic fine phase shift port (PSEN/PSINCDEC/PSDONE) on one MMCM output, e.g. the phase-offset ADC sampling clock.
- Accepts absolute phase targets from the host/config logic.
- Steps the MMCM along the shortest wrap-around path, one PSEN pulse at a time, and tracks the current position.
- Sits beside the global clock generator and runs on the MMCM PS clock domain.

---
 rtl/mmcm_phase_stepper_pkg.sv | 16 +
 rtl/mmcm_phase_stepper_if.sv | 26 ++
 rtl/mmcm_phase_stepper_phase_dir_calc.sv | 29 ++
 rtl/mmcm_phase_stepper.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/mmcm_phase_stepper_pkg.sv
// Shared types for the MMCM fine-phase stepper: FSM states and error codes.
package mmcm_phase_stepper_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        IDLE      = 2'd1,
        ISSUE     = 2'd2,
        WAIT_DONE = 2'd3
    } state_e;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_RANGE   = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_UNLOCK  = 2'd3;

endpackage

// File: rtl/mmcm_phase_stepper_if.sv
// Target request, MMCM dynamic phase-shift port and status bundle of the stepper.
interface mmcm_phase_stepper_if #(
    parameter int POS_W = 16
);
    logic             tgt_valid;
    logic             tgt_ready;
    logic [POS_W-1:0] tgt_pos;
    logic             psen;
    logic             psincdec;
    logic             psdone;
    logic [POS_W-1:0] cur_pos;
    logic             busy;
    logic             done;
    logic             err;
    logic [1:0]       err_code;

    modport slave (
        input  tgt_valid, tgt_pos, psdone,
        output tgt_ready, psen, psincdec, cur_pos, busy, done, err, err_code
    );

    modport master (
        output tgt_valid, tgt_pos, psdone,
        input  tgt_ready, psen, psincdec, cur_pos, busy, done, err, err_code
    );
endinterface

// File: rtl/mmcm_phase_stepper_phase_dir_calc.sv
// Modular distance from cur to tgt around one revolution; inc=1 when the forward
// path is no longer than half a turn (a tie goes forward). Purely combinational.
module phase_dir_calc #(
    parameter int STEPS_PER_REV = 224,
    parameter int POS_W         = 16
) (
    input  logic [POS_W-1:0] cur_pos,
    input  logic [POS_W-1:0] tgt_pos,
    output logic [POS_W-1:0] diff,
    output logic             inc
);
    localparam logic [POS_W:0] STEPS_X = (POS_W+1)'(STEPS_PER_REV);

    logic [POS_W:0] cur_x;
    logic [POS_W:0] tgt_x;
    logic [POS_W:0] raw;

    always_comb begin
        cur_x = {1'b0, cur_pos};
        tgt_x = {1'b0, tgt_pos};
        if (tgt_x >= cur_x) begin
            raw = tgt_x - cur_x;
        end else begin
            raw = tgt_x + STEPS_X - cur_x;
        end
        diff = raw[POS_W-1:0];
        inc  = (raw <= (STEPS_X >> 1));
    end
endmodule

// File: rtl/mmcm_phase_stepper.sv
// Walks the MMCM fine phase shift to an absolute target along the shortest path,
// one PSEN pulse per PSDONE, holding off requests until LOCKED has been stable.
module mmcm_phase_stepper
    import mmcm_phase_stepper_pkg::*;
#(
    parameter int STEPS_PER_REV = 224,
    parameter int POS_W         = 16,
    parameter int LOCK_WAIT     = 64,
    parameter int DONE_TIMEOUT  = 31
) (
    input  logic                 clk_in,
    input  logic                 rst_n,
    input  logic                 locked,
    mmcm_phase_stepper_if.slave  ps_if
);
    localparam int LCNT_W = $clog2(LOCK_WAIT);
    localparam int TCNT_W = $clog2(DONE_TIMEOUT);
    localparam logic [LCNT_W-1:0] LOCK_LAST = LCNT_W'(LOCK_WAIT - 1);
    // Counter starts in the first WAIT_DONE cycle, so err lands DONE_TIMEOUT cycles after psen.
    localparam logic [TCNT_W-1:0] TO_LAST   = TCNT_W'(DONE_TIMEOUT - 2);
    localparam logic [POS_W-1:0]  LAST_POS  = POS_W'(STEPS_PER_REV - 1);
    localparam logic [POS_W:0]    STEPS_X   = (POS_W+1)'(STEPS_PER_REV);

    state_e             state_q,    state_d;
    logic [LCNT_W-1:0]  lock_cnt_q, lock_cnt_d;
    logic [TCNT_W-1:0]  to_cnt_q,   to_cnt_d;
    logic [POS_W-1:0]   tgt_q,      tgt_d;
    logic [POS_W-1:0]   cur_pos_q,  cur_pos_d;
    logic               psen_q,     psen_d;
    logic               psincdec_q, psincdec_d;
    logic               done_q,     done_d;
    logic               err_q,      err_d;
    logic [1:0]         err_code_q, err_code_d;

    logic [POS_W-1:0]   diff;
    logic               dir_inc;
    logic [POS_W-1:0]   next_pos;

    phase_dir_calc #(
        .STEPS_PER_REV (STEPS_PER_REV),
        .POS_W         (POS_W)
    ) u_dir (
        .cur_pos (cur_pos_q),
        .tgt_pos (ps_if.tgt_pos),
        .diff    (diff),
        .inc     (dir_inc)
    );

    always_comb begin
        if (psincdec_q) begin
            next_pos = (cur_pos_q == LAST_POS) ? '0 : cur_pos_q + 1'b1;
        end else begin
            next_pos = (cur_pos_q == '0) ? LAST_POS : cur_pos_q - 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        to_cnt_d   = to_cnt_q;
        tgt_d      = tgt_q;
        cur_pos_d  = cur_pos_q;
        psen_d     = 1'b0;
        psincdec_d = psincdec_q;
        done_d     = 1'b0;
        err_d      = err_q;
        err_code_d = err_code_q;

        if (state_q != WAIT_LOCK && !locked) begin
            // MMCM re-locks at zero shift; only an interrupted move is an error.
            state_d    = WAIT_LOCK;
            lock_cnt_d = '0;
            cur_pos_d  = '0;
            if (state_q != IDLE) begin
                err_d      = 1'b1;
                err_code_d = ERR_UNLOCK;
            end
        end else begin
            unique case (state_q)
                WAIT_LOCK: begin
                    if (!locked) begin
                        lock_cnt_d = '0;
                    end else if (lock_cnt_q == LOCK_LAST) begin
                        state_d    = IDLE;
                        lock_cnt_d = '0;
                    end else begin
                        lock_cnt_d = lock_cnt_q + 1'b1;
                    end
                end
                IDLE: begin
                    if (ps_if.tgt_valid) begin
                        err_d      = 1'b0;
                        err_code_d = ERR_NONE;
                        tgt_d      = ps_if.tgt_pos;
                        if ({1'b0, ps_if.tgt_pos} >= STEPS_X) begin
                            err_d      = 1'b1;
                            err_code_d = ERR_RANGE;
                        end else if (diff == '0) begin
                            done_d = 1'b1;
                        end else begin
                            psincdec_d = dir_inc;
                            psen_d     = 1'b1;
                            state_d    = ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    to_cnt_d = '0;
                    state_d  = WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (ps_if.psdone) begin
                        cur_pos_d = next_pos;
                        if (next_pos == tgt_q) begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            psen_d  = 1'b1;
                            state_d = ISSUE;
                        end
                    end else if (to_cnt_q == TO_LAST) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_TIMEOUT;
                        state_d    = IDLE;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end
                default: state_d = WAIT_LOCK;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= WAIT_LOCK;
            lock_cnt_q <= '0;
            to_cnt_q   <= '0;
            tgt_q      <= '0;
            cur_pos_q  <= '0;
            psen_q     <= 1'b0;
            psincdec_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            to_cnt_q   <= to_cnt_d;
            tgt_q      <= tgt_d;
            cur_pos_q  <= cur_pos_d;
            psen_q     <= psen_d;
            psincdec_q <= psincdec_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign ps_if.tgt_ready = (state_q == IDLE);
    assign ps_if.busy      = (state_q != IDLE);
    assign ps_if.psen      = psen_q;
    assign ps_if.psincdec  = psincdec_q;
    assign ps_if.cur_pos   = cur_pos_q;
    assign ps_if.done      = done_q;
    assign ps_if.err       = err_q;
    assign ps_if.err_code  = err_code_q;
endmodule
